pool_flatten_ctrl: RTL and testbench

// - Sequencer for the ReLU -> 2x2 max-pool -> flatten path; sits between the ReLU stage and the FC layer.
// - Accepts one raster-ordered frame of ReLU pixels, with all CI channels in parallel.
// - Drives line-buffer shift/clear and captures pooled values at stride-2 window positions.
// - Packs them channel-major into an FC input vector and hands it off with a valid/ready handshake.

---
 rtl/pool_flatten_ctrl_pkg.sv | 31 +++
 rtl/pool_flatten_ctrl_pos.sv | 64 ++++++
 rtl/pool_flatten_ctrl.sv | 105 ++++++++++
 tb/tb_pool_flatten_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_flatten_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the ReLU -> 2x2 max-pool
// -> flatten sequencer.
//   CI_DEF / IMG_W_DEF / BW_DEF : default channel count, frame side, value width
//   POOL_K                      : pooling window side (stride equals window)
//   ST_*                        : legacy 2-bit state encodings
//   state_t                     : FSM state type built on those encodings
//   fc_index()                  : flattened element index, channel-major
package pool_flatten_ctrl_pkg;

  localparam int CI_DEF    = 3;
  localparam int IMG_W_DEF = 8;
  localparam int BW_DEF    = 32;
  localparam int POOL_K    = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_LAST = ST_LAST,
    S_OUT  = ST_OUT
  } state_t;

  function automatic int fc_index(input int ch, input int slot, input int p_size);
    return ch * p_size * p_size + slot;
  endfunction

endpackage

// File: rtl/pool_flatten_ctrl_pos.sv
// pool_pos_counter: raster position tracker for the pooling window.
//   clk, reset_n : clock, asynchronous active-high reset
//   clear        : return row/col to the frame origin
//   advance      : one pixel accepted this cycle
//   last_pix     : the pixel accepted this cycle is the last of the frame
//   cap_flag     : registered; previous accept completed a 2x2 window
//   cap_slot     : registered pooled slot index (pr*P_SIZE + pc) for cap_flag
module pool_pos_counter
  import pool_flatten_ctrl_pkg::*;
#(
  parameter  int IMG_W  = IMG_W_DEF,
  localparam int P_SIZE = IMG_W / POOL_K,
  localparam int CW     = $clog2(IMG_W),
  localparam int SW     = $clog2(P_SIZE * P_SIZE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic          last_pix,
  output logic          cap_flag,
  output logic [SW-1:0] cap_slot
);

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          row_end;
  logic          col_end;
  logic          odd_odd;
  logic [SW-1:0] slot_now;

  always_comb begin
    row_end  = (row == CW'(IMG_W - 1));
    col_end  = (col == CW'(IMG_W - 1));
    // Bottom-right pixel of a 2x2 window sits at odd row and odd column.
    odd_odd  = row[0] & col[0];
    slot_now = SW'(row >> 1) * SW'(P_SIZE) + SW'(col >> 1);
    last_pix = advance & row_end & col_end;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      row      <= '0;
      col      <= '0;
      cap_flag <= 1'b0;
      cap_slot <= '0;
    end else begin
      cap_flag <= advance & odd_odd;
      if (advance & odd_odd) cap_slot <= slot_now;
      if (clear) begin
        row <= '0;
        col <= '0;
      end else if (advance) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pool_flatten_ctrl.sv
// pool_flatten_ctrl: sequencer for ReLU -> 2x2 max-pool -> flatten.
//   clk, reset_n  : clock, asynchronous active-high reset
//   i_start       : frame start, honoured in IDLE only
//   i_relu_valid  : upstream pixel valid; o_relu_ready accepts it in RUN
//   o_lb_shift    : line-buffer shift, equals pixel accept
//   o_lb_clear    : line-buffer clear, same cycle as an honoured start
//   i_pool_vec    : per-channel 2x2 window max, sampled in capture cycles
//   o_fc_valid    : flattened vector offered; i_fc_ready completes handoff
//   o_fc_vec      : element ch*P_SIZE^2 + pr*P_SIZE + pc
//   o_busy        : not IDLE
//   o_frame_done  : one-cycle pulse the cycle after the vector handshake
module pool_flatten_ctrl
  import pool_flatten_ctrl_pkg::*;
#(
  parameter  int CI     = CI_DEF,
  parameter  int IMG_W  = IMG_W_DEF,
  parameter  int BW     = BW_DEF,
  localparam int P_SIZE = IMG_W / POOL_K,
  localparam int PP     = P_SIZE * P_SIZE,
  localparam int FC_VEC = CI * PP,
  localparam int SW     = $clog2(PP)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_relu_valid,
  output logic               o_relu_ready,
  output logic               o_lb_shift,
  output logic               o_lb_clear,
  input  logic [CI*BW-1:0]   i_pool_vec,
  output logic               o_fc_valid,
  input  logic               i_fc_ready,
  output logic [FC_VEC*BW-1:0] o_fc_vec,
  output logic               o_busy,
  output logic               o_frame_done
);

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          last_pix;
  logic          cap_flag;
  logic [SW-1:0] cap_slot;
  logic [BW-1:0] fc_buf [FC_VEC];

  always_comb begin
    o_relu_ready = (state == S_RUN);
    accept       = o_relu_ready & i_relu_valid;
    o_lb_shift   = accept;
    o_lb_clear   = (state == S_IDLE) & i_start;
    o_fc_valid   = (state == S_OUT);
    o_busy       = (state != S_IDLE);
  end

  pool_pos_counter #(
    .IMG_W (IMG_W)
  ) u_pos (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (o_lb_clear),
    .advance  (accept),
    .last_pix (last_pix),
    .cap_flag (cap_flag),
    .cap_slot (cap_slot)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start)    state_nxt = S_RUN;
      S_RUN:  if (last_pix)   state_nxt = S_LAST;
      // LAST exists only to let the final window's capture land before OUT.
      S_LAST:                 state_nxt = S_OUT;
      S_OUT:  if (i_fc_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state        <= S_IDLE;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_frame_done <= (state == S_OUT) & i_fc_ready;
    end
  end

  // Slots are overwritten in place; the previous frame stays visible until
  // the next frame's captures reach each slot.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int unsigned i = 0; i < FC_VEC; i++) fc_buf[i] <= '0;
    end else if (cap_flag) begin
      for (int unsigned ch = 0; ch < CI; ch++)
        fc_buf[fc_index(int'(ch), int'(cap_slot), P_SIZE)] <= i_pool_vec[ch*BW +: BW];
    end
  end

  always_comb begin
    o_fc_vec = '0;
    for (int unsigned i = 0; i < FC_VEC; i++) o_fc_vec[i*BW +: BW] = fc_buf[i];
  end

endmodule

// File: tb/tb_pool_flatten_ctrl.sv
// Directed bench for pool_flatten_ctrl: ramp frames, stalls, OUT backpressure,
// ignored mid-frame start, mid-frame reset and back-to-back frames.
module tb_pool_flatten_ctrl;

  localparam int CI    = 3;
  localparam int IMG_W = 8;
  localparam int BW    = 32;
  localparam int P     = IMG_W / 2;
  localparam int PP    = P * P;
  localparam int FCV   = CI * PP;
  localparam int NPIX  = IMG_W * IMG_W;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic i_start = 1'b0;
  logic i_relu_valid = 1'b0;
  logic i_fc_ready = 1'b0;
  logic [CI*BW-1:0] i_pool_vec = '0;
  logic o_relu_ready, o_lb_shift, o_lb_clear, o_fc_valid, o_busy, o_frame_done;
  logic [FCV*BW-1:0] o_fc_vec;

  int errors = 0;
  int checks = 0;

  int fr_base;
  bit fr_neg;
  int cur_r, cur_c, n_acc, n_shift, n_clear, n_shift_bad;
  bit acc_prev;
  int acc_r, acc_c;

  always #5 clk = ~clk;

  pool_flatten_ctrl #(
    .CI    (CI),
    .IMG_W (IMG_W),
    .BW    (BW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_relu_valid (i_relu_valid),
    .o_relu_ready (o_relu_ready),
    .o_lb_shift   (o_lb_shift),
    .o_lb_clear   (o_lb_clear),
    .i_pool_vec   (i_pool_vec),
    .o_fc_valid   (o_fc_valid),
    .i_fc_ready   (i_fc_ready),
    .o_fc_vec     (o_fc_vec),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame pixel; optional negatives never land on a window's bottom-right.
  function automatic int pix(input int k, input int r, input int c);
    int v;
    v = fr_base + 100*k + 8*r + c;
    if (fr_neg && ((r + c) % 3 == 0) && !((r % 2 == 1) && (c % 2 == 1))) v = -v;
    return v;
  endfunction

  function automatic int win_max(input int k, input int pr, input int pc);
    int m;
    m = pix(k, 2*pr, 2*pc);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (pix(k, 2*pr+dr, 2*pc+dc) > m) m = pix(k, 2*pr+dr, 2*pc+dc);
    return m;
  endfunction

  function automatic int exp_elem(input int idx);
    int ch, slot, pr, pc;
    ch   = idx / PP;
    slot = idx % PP;
    pr   = slot / P;
    pc   = slot % P;
    return fr_base + 100*ch + 8*(2*pr+1) + 2*pc + 1;
  endfunction

  task automatic check_vec(input string tag);
    for (int i = 0; i < FCV; i++)
      chk($sformatf("%s[%0d]", tag, i), $signed(o_fc_vec[i*BW +: BW]), exp_elem(i));
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic cycle(input logic v, input logic s, input logic rdy);
    @(negedge clk);
    i_relu_valid = v;
    i_start      = s;
    i_fc_ready   = rdy;
    if (acc_prev && (acc_r % 2 == 1) && (acc_c % 2 == 1)) begin
      for (int k = 0; k < CI; k++) i_pool_vec[k*BW +: BW] = win_max(k, acc_r/2, acc_c/2);
    end else begin
      i_pool_vec = {$urandom, $urandom, $urandom};
    end
    #1;
    if (o_lb_clear === 1'b1) n_clear++;
    if (o_lb_shift === 1'b1) n_shift++;
    if (o_lb_shift !== (v & o_relu_ready)) n_shift_bad++;
    acc_prev = (o_relu_ready === 1'b1) && v;
    if (acc_prev) begin
      acc_r = cur_r;
      acc_c = cur_c;
      n_acc++;
      if (cur_c == IMG_W-1) begin
        cur_c = 0;
        cur_r = (cur_r + 1) % IMG_W;
      end else begin
        cur_c++;
      end
    end
  endtask

  task automatic run_frame(input int base, input bit neg, input bit gaps,
                           input int start_at, input int stop_at, input logic rdy);
    int  guard;
    bit  sent;
    logic v, s;
    fr_base = base; fr_neg = neg;
    cur_r = 0; cur_c = 0; n_acc = 0;
    n_shift = 0; n_clear = 0; n_shift_bad = 0;
    sent = 0; guard = 0;
    cycle(1'b0, 1'b1, 1'b0);
    chk("start_clear", o_lb_clear, 1);
    chk("start_busy", o_busy, 0);
    chk("done_single", o_frame_done, 0);
    while (n_acc < stop_at && guard < 1000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s = 1'b0;
      if (n_acc == start_at && !sent) begin
        s = 1'b1;
        sent = 1;
      end
      cycle(v, s, rdy);
      if (guard == 0) chk("run_ready", o_relu_ready, 1);
      guard++;
    end
    chk("accepts", n_acc, stop_at);
  endtask

  task automatic finish_frame(input int hold);
    int bad;
    cycle(1'b1, 1'b0, 1'b0);
    chk("last_ready", o_relu_ready, 0);
    chk("last_valid", o_fc_valid, 0);
    chk("last_busy", o_busy, 1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("out_valid", o_fc_valid, 1);
    check_vec("vec");
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (o_fc_valid !== 1'b1 || o_relu_ready !== 1'b0 ||
          o_lb_shift !== 1'b0 || o_lb_clear !== 1'b0 || o_busy !== 1'b1) bad++;
    end
    chk("out_hold", bad, 0);
    if (hold > 0) check_vec("vec_held");
    cycle(1'b0, 1'b0, 1'b1);
    chk("hs_valid", o_fc_valid, 1);
    chk("hs_done_early", o_frame_done, 0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("done_pulse", o_frame_done, 1);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_fc_valid, 0);
    chk("shift_count", n_shift, NPIX);
    chk("clear_count", n_clear, 1);
    chk("shift_eq_accept", n_shift_bad, 0);
  endtask

  initial begin
    acc_prev = 0;
    fr_base = 0;
    fr_neg = 0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", o_relu_ready, 0);
    chk("rst_shift", o_lb_shift, 0);
    chk("rst_clear", o_lb_clear, 0);
    chk("rst_valid", o_fc_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_vec", |o_fc_vec, 0);
    @(negedge clk);
    reset_n = 1'b0;

    // Ramp frame, no stalls, 20 cycles of OUT backpressure.
    run_frame(0, 0, 0, -1, NPIX, 1'b0);
    finish_frame(20);

    // Partial frame, then reset at pixel 40.
    run_frame(500, 0, 0, -1, 40, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    i_relu_valid = 1'b1;
    #1;
    chk("mrst_ready", o_relu_ready, 0);
    chk("mrst_shift", o_lb_shift, 0);
    chk("mrst_clear", o_lb_clear, 0);
    chk("mrst_valid", o_fc_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_done", o_frame_done, 0);
    chk("mrst_vec", |o_fc_vec, 0);
    acc_prev = 0;
    @(negedge clk);
    reset_n = 1'b0;
    i_relu_valid = 1'b0;

    // Stalled frame with negatives, stray start at pixel 30, early fc_ready.
    run_frame(0, 1, 1, 30, NPIX, 1'b1);
    finish_frame(3);

    // Back-to-back frame with a different base.
    run_frame(1000, 0, 0, -1, NPIX, 1'b0);
    finish_frame(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
